iq_integrate_dump: RTL



---
 rtl/iq_integrate_dump_pkg.sv | 25 ++
 rtl/iq_accum_channel.sv | 70 +++++++
 rtl/iq_integrate_dump.sv | 103 ++++++++++
 3 files changed

// File: rtl/iq_integrate_dump_pkg.sv
// Shared widths, window-control actions and rounding constant for iq_integrate_dump.
package iq_integrate_dump_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_ACC,
        ACT_DUMP,
        ACT_CLEAR,
        ACT_RESTART
    } win_act_e;

    function automatic int acc_width(input int bit_width, input int decim_log2);
        return bit_width + decim_log2;
    endfunction

    function automatic int pwr_width(input int bit_width);
        return 2 * bit_width + 1;
    endfunction

    // Half an output LSB in accumulator units; zero when there is no decimation.
    function automatic int round_const(input int decim_log2);
        return (decim_log2 == 0) ? 0 : (1 << (decim_log2 - 1));
    endfunction

endpackage

// File: rtl/iq_accum_channel.sv
// One I or Q integrate-and-dump lane; IQ_INTEGRATE_DUMP_ROUND_EN adds round-half-up with saturation.
module iq_accum_channel
    import iq_integrate_dump_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int DECIM_LOG2 = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  win_act_e                    act,
    input  logic signed [BIT_WIDTH-1:0] sample,
    output logic signed [BIT_WIDTH-1:0] out
);

    localparam int ACC_W = acc_width(BIT_WIDTH, DECIM_LOG2);

    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [BIT_WIDTH-1:0] out_q, out_d;
    logic signed [ACC_W-1:0]     sample_x;
    logic signed [ACC_W-1:0]     sum;
    logic signed [BIT_WIDTH-1:0] dump_val;

`ifdef IQ_INTEGRATE_DUMP_ROUND_EN
    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(round_const(DECIM_LOG2));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (BIT_WIDTH - 1)) - 1);
    logic signed [ACC_W:0] sum_r;
    logic signed [ACC_W:0] sum_sh;
`endif

    always_comb begin
        sample_x = ACC_W'(sample);
        sum      = acc_q + sample_x;
`ifdef IQ_INTEGRATE_DUMP_ROUND_EN
        // One guard bit keeps the rounding add from wrapping at full scale.
        sum_r    = {sum[ACC_W-1], sum} + RND;
        sum_sh   = sum_r >>> DECIM_LOG2;
        dump_val = (sum_sh > SAT_MAX) ? SAT_MAX[BIT_WIDTH-1:0] : sum_sh[BIT_WIDTH-1:0];
`else
        dump_val = BIT_WIDTH'(sum >>> DECIM_LOG2);
`endif
    end

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        unique case (act)
            ACT_ACC:     acc_d = sum;
            ACT_DUMP: begin
                acc_d = '0;
                out_d = dump_val;
            end
            ACT_CLEAR:   acc_d = '0;
            ACT_RESTART: acc_d = sample_x;
            default:     acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/iq_integrate_dump.sv
// Decimating I/Q integrate-and-dump with pipelined power estimate.
// Optional IQ_INTEGRATE_DUMP_ROUND_EN selects rounded, saturating averages.
module iq_integrate_dump
    import iq_integrate_dump_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int DECIM_LOG2 = 3
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                strobe_in,
    input  logic                                sync,
    input  logic signed [BIT_WIDTH-1:0]         i_in,
    input  logic signed [BIT_WIDTH-1:0]         q_in,
    output logic signed [BIT_WIDTH-1:0]         i_out,
    output logic signed [BIT_WIDTH-1:0]         q_out,
    output logic                                strobe_out,
    output logic [pwr_width(BIT_WIDTH)-1:0]     pwr_out,
    output logic                                strobe_pwr
);

    localparam int PWR_W = pwr_width(BIT_WIDTH);
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DECIM_LOG2) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_out_q, strobe_out_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic             strobe_pwr_q, strobe_pwr_d;
    win_act_e         act;
    logic             sync_eff;

    logic signed [2*BIT_WIDTH-1:0] i_ext, q_ext;
    logic [2*BIT_WIDTH-1:0]        i_sq, q_sq;

    // Without decimation every sample dumps, so a restart would be indistinguishable.
    assign sync_eff = sync && (DECIM_LOG2 != 0);

    always_comb begin
        act   = ACT_HOLD;
        cnt_d = cnt_q;
        if (sync_eff && strobe_in) begin
            act   = ACT_RESTART;
            cnt_d = CNT_W'(1);
        end else if (sync_eff) begin
            act   = ACT_CLEAR;
            cnt_d = '0;
        end else if (strobe_in && (cnt_q == CNT_MAX)) begin
            act   = ACT_DUMP;
            cnt_d = '0;
        end else if (strobe_in) begin
            act   = ACT_ACC;
            cnt_d = cnt_q + CNT_W'(1);
        end
        strobe_out_d = (act == ACT_DUMP);
    end

    always_comb begin
        i_ext        = (2*BIT_WIDTH)'(i_out);
        q_ext        = (2*BIT_WIDTH)'(q_out);
        i_sq         = i_ext * i_ext;
        q_sq         = q_ext * q_ext;
        pwr_d        = pwr_q;
        strobe_pwr_d = strobe_out_q;
        if (strobe_out_q)
            pwr_d = PWR_W'(i_sq) + PWR_W'(q_sq);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            strobe_out_q <= 1'b0;
            pwr_q        <= '0;
            strobe_pwr_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            strobe_out_q <= strobe_out_d;
            pwr_q        <= pwr_d;
            strobe_pwr_q <= strobe_pwr_d;
        end
    end

    iq_accum_channel #(.BIT_WIDTH(BIT_WIDTH), .DECIM_LOG2(DECIM_LOG2)) u_i (
        .clock  (clock),
        .reset  (reset),
        .act    (act),
        .sample (i_in),
        .out    (i_out)
    );

    iq_accum_channel #(.BIT_WIDTH(BIT_WIDTH), .DECIM_LOG2(DECIM_LOG2)) u_q (
        .clock  (clock),
        .reset  (reset),
        .act    (act),
        .sample (q_in),
        .out    (q_out)
    );

    assign strobe_out = strobe_out_q;
    assign pwr_out    = pwr_q;
    assign strobe_pwr = strobe_pwr_q;

endmodule
